slurm_irq_controller: RTL

Prioritised interrupt controller for the slurm16 SoC. Collects rising-edge interrupt events from peripherals (GPIO inputs, UART, audio, video vsync, flash DMA), latches them as pending, masks them, and presents the highest-priority enabled request to the CPU core through a request/acknowledge/end-of-interrupt handshake. It sits on the CPU I/O port bus as a memory-mapped register peripheral and drives the core's interrupt input.

---
 rtl/slurm_irq_pkg.sv | 35 +++
 rtl/slurm_irq_edge_detect.sv | 39 +++
 rtl/slurm_irq_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/slurm_irq_pkg.sv
// slurm_irq_pkg -- shared definitions for the slurm16 interrupt controller.
//   Register map (4-bit port address), FSM state encoding, STATUS bit
//   positions and the priority-encoder helper used at vector selection.
package slurm_irq_pkg;

  // Register addresses on the CPU port bus
  localparam logic [3:0] IRQ_ENABLE  = 4'd0;
  localparam logic [3:0] IRQ_PENDING = 4'd1;
  localparam logic [3:0] IRQ_STATUS  = 4'd2;
  localparam logic [3:0] IRQ_EOI     = 4'd3;
  localparam logic [3:0] IRQ_FORCE   = 4'd4;

  // STATUS register layout
  localparam int STAT_INSVC_BIT = 15;
  localparam int STAT_IRQ_BIT   = 14;
  localparam int STAT_VEC_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Lowest set index wins (index 0 is highest priority). Returns 0 for an
  // all-zero input; callers test for a non-zero vector first.
  function automatic logic [3:0] prio_lowest(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/slurm_irq_edge_detect.sv
// slurm_irq_edge_detect -- one interrupt source: optional two-flop
// synchroniser followed by a rising-edge detector.
//   Build option: SLURM_IRQ_SYNC_EN defined -> src_i passes through a
//   two-flop synchroniser first (two extra cycles of latency). Undefined ->
//   src_i is assumed synchronous and sampled directly.
// Ports:
//   clk_i   in  clock
//   rst_ni  in  async active-low reset (clears history)
//   src_i   in  raw interrupt line
//   rise_o  out one-cycle pulse in the cycle a 0->1 transition is seen
module slurm_irq_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic rise_o
);

  logic samp;
  logic prev_q;

`ifdef SLURM_IRQ_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], src_i};
  end
  assign samp = sync_q[1];
`else
  assign samp = src_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= samp;
  end

  assign rise_o = samp & ~prev_q;

endmodule

// File: rtl/slurm_irq_controller.sv
// slurm_irq_controller -- prioritised interrupt controller for slurm16.
//   Latches rising edges from NUM_IRQ sources into PENDING, masks with
//   ENABLE, and presents the highest-priority request to the core through a
//   req / ack / EOI handshake. Memory-mapped on the port bus:
//     0 ENABLE  RW   1 PENDING R/W1C   2 STATUS R   3 EOI W   4 FORCE W1S
//   Build option: SLURM_IRQ_SYNC_EN (see slurm_irq_edge_detect).
// Ports:
//   CLK, RSTb           clock, async active-low reset
//   irq_src[NUM_IRQ]    raw source lines (rising-edge sensitive)
//   ADDRESS/DATA_IN/WR  port-bus register write / address
//   DATA_OUT            registered read data for ADDRESS
//   cpu_irq             request to core
//   cpu_irq_vector      requested source index
//   cpu_irq_ack         single-cycle acknowledge from core
module slurm_irq_controller
  import slurm_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               CLK,
  input  logic               RSTb,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [3:0]         ADDRESS,
  input  logic [15:0]        DATA_IN,
  input  logic               WR,
  output logic [15:0]        DATA_OUT,
  output logic               cpu_irq,
  output logic [3:0]         cpu_irq_vector,
  input  logic               cpu_irq_ack
);

  // Registers are kept 16 wide; bits at and above NUM_IRQ are forced to 0
  // so indexing by a 4-bit vector never goes out of range.
  localparam logic [15:0] IRQ_MASK = 16'((32'h1 << NUM_IRQ) - 32'h1);

  logic [NUM_IRQ-1:0] rise;
  logic [15:0]        rise16;
  logic [15:0]        en_q, en_d;
  logic [15:0]        pend_q, pend_d;
  logic [15:0]        ack_clr;
  logic [15:0]        req_vec;
  logic [15:0]        rd_data;
  logic [15:0]        dout_q;
  logic [3:0]         vec_q, vec_d;
  irq_state_e         state_q, state_d;
  logic               wr_en, wr_pend, wr_eoi, wr_force;
  logic               ack_take;

  // Per-source edge detectors
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_edge
    slurm_irq_edge_detect u_edge (
      .clk_i  (CLK),
      .rst_ni (RSTb),
      .src_i  (irq_src[g]),
      .rise_o (rise[g])
    );
  end

  always_comb begin
    rise16 = '0;
    rise16[NUM_IRQ-1:0] = rise;
  end

  // Write decode
  assign wr_en    = WR && (ADDRESS == IRQ_ENABLE);
  assign wr_pend  = WR && (ADDRESS == IRQ_PENDING);
  assign wr_eoi   = WR && (ADDRESS == IRQ_EOI);
  assign wr_force = WR && (ADDRESS == IRQ_FORCE);

  assign req_vec = pend_q & en_q;

  // FSM next state. Vector is chosen only on the IDLE->REQ transition and
  // stays frozen through REQ and SERVICE.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          vec_d   = prio_lowest(req_vec);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack takes precedence over a simultaneous withdraw.
        if (cpu_irq_ack) begin
          ack_take = 1'b1;
          state_d  = ST_SERVICE;
        end else if (!(pend_q[vec_q] && en_q[vec_q])) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack_clr = ack_take ? (16'h1 << vec_q) : 16'h0;

  // Clears (W1C, ack) are applied before sets (edge, FORCE) so a set in the
  // same cycle always survives.
  always_comb begin
    pend_d = pend_q & ~ack_clr;
    if (wr_pend)  pend_d = pend_d & ~DATA_IN;
    pend_d = pend_d | rise16;
    if (wr_force) pend_d = pend_d | DATA_IN;
    pend_d = pend_d & IRQ_MASK;
  end

  assign en_d = wr_en ? (DATA_IN & IRQ_MASK) : en_q;

  // Read mux, registered into DATA_OUT
  always_comb begin
    rd_data = '0;
    case (ADDRESS)
      IRQ_ENABLE:  rd_data = en_q;
      IRQ_PENDING: rd_data = pend_q;
      IRQ_STATUS: begin
        rd_data[STAT_INSVC_BIT]             = (state_q == ST_SERVICE);
        rd_data[STAT_IRQ_BIT]               = (state_q == ST_REQ);
        rd_data[STAT_VEC_LSB+3:STAT_VEC_LSB] = vec_q;
      end
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      dout_q  <= rd_data;
    end
  end

  assign DATA_OUT       = dout_q;
  assign cpu_irq        = (state_q == ST_REQ);
  assign cpu_irq_vector = vec_q;

endmodule
